// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and register-select widths, plus the
// register-dump sequencer state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/register_file.sv
// 32 x 32-bit register file, two async read ports, one write port.
// Register 0 reads as zero; a write is forwarded to a same-cycle read.
module register_file
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     WEN,
    input  regbits_t wsel,
    input  word_t    wdat,
    input  regbits_t rsel1,
    input  regbits_t rsel2,
    output word_t    rdat1,
    output word_t    rdat2
);

    word_t regs [NUM_REGS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs <= '{default: '0};
        end else if (WEN && (wsel != '0)) begin
            regs[wsel] <= wdat;
        end
    end

    function automatic word_t read_port(input regbits_t sel, input word_t stored,
                                        input logic wen, input regbits_t wsel_i,
                                        input word_t wdat_i);
        word_t val;
        val = stored;
        if (sel == '0) begin
            val = '0;
        end else if (wen && (wsel_i == sel)) begin
            val = wdat_i;
        end
        return val;
    endfunction

    assign rdat1 = read_port(rsel1, regs[rsel1], WEN, wsel, wdat);
    assign rdat2 = read_port(rsel2, regs[rsel2], WEN, wsel, wdat);

endmodule

// File: rtl/regfile_dump.sv
// Sweeps a register range through the register-file read port and streams
// each (index, value) pair out over a valid/ready handshake.
module regfile_dump
    import cpu_types_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     start,
    input  regbits_t first_idx,
    input  regbits_t last_idx,
    output regbits_t rsel,
    input  word_t    rdat,
    output logic     out_valid,
    input  logic     out_ready,
    output regbits_t out_idx,
    output word_t    out_data,
    output logic     busy,
    output logic     done
);

    dump_state_t state;
    regbits_t    cur;
    regbits_t    end_idx;

    regbits_t cur_next_c;
    logic     skip_c;
    logic     at_end_c;

    // Index increment wraps 31 -> 0 through the 5-bit width.
    assign cur_next_c = cur + regbits_t'(1);
    assign skip_c     = SKIP_ZERO && (cur == '0);
    assign at_end_c   = (cur == end_idx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cur       <= '0;
            end_idx   <= '0;
            rsel      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur     <= first_idx;
                        end_idx <= last_idx;
                        rsel    <= first_idx;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    rsel <= '0;
                    if (skip_c) begin
                        // Skipped index advances without a capture/handshake.
                        if (at_end_c) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur  <= cur_next_c;
                            rsel <= cur_next_c;
                        end
                    end else begin
                        out_data  <= rdat;
                        out_idx   <= cur;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (at_end_c) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur   <= cur_next_c;
                            rsel  <= cur_next_c;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench: two dump sequencers (SKIP_ZERO 0 and 1) share one register file and
// are compared against a queue-based reference of the expected word stream.
module tb_regfile_dump;
    import cpu_types_pkg::*;

    localparam int unsigned BOUND = 400;

    typedef struct packed {
        regbits_t idx;
        word_t    data;
    } rec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic     RST;
    logic     nRST;
    logic     WEN;
    regbits_t wsel;
    word_t    wdat;
    logic     start;
    regbits_t first_idx;
    logic     out_ready;
    regbits_t last_idx;

    regbits_t rs   [2];
    word_t    rd   [2];
    regbits_t oidx [2];
    word_t    odat [2];
    logic [1:0] vld;
    logic [1:0] bsy;
    logic [1:0] dn;

    word_t mregs [32];
    rec_t  q0 [$];
    rec_t  q1 [$];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    register_file u_rf (
        .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .rsel1(rs[0]), .rsel2(rs[1]), .rdat1(rd[0]), .rdat2(rd[1])
    );

    regfile_dump #(.SKIP_ZERO(1'b0)) u_dut0 (
        .CLK(CLK), .RST(RST), .start(start), .first_idx(first_idx),
        .last_idx(last_idx), .rsel(rs[0]), .rdat(rd[0]), .out_valid(vld[0]),
        .out_ready(out_ready), .out_idx(oidx[0]), .out_data(odat[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    regfile_dump #(.SKIP_ZERO(1'b1)) u_dut1 (
        .CLK(CLK), .RST(RST), .start(start), .first_idx(first_idx),
        .last_idx(last_idx), .rsel(rs[1]), .rdat(rd[1]), .out_valid(vld[1]),
        .out_ready(out_ready), .out_idx(oidx[1]), .out_data(odat[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rf_write(input regbits_t a, input word_t v);
        @(negedge CLK);
        WEN = 1'b1; wsel = a; wdat = v;
        @(negedge CLK);
        WEN = 1'b0;
        if (a != '0) mregs[a] = v;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_valid", tag, d), 32'(vld[d]), 32'd0);
            check($sformatf("%s_d%0d_done", tag, d), 32'(dn[d]), 32'd0);
            check($sformatf("%s_d%0d_busy", tag, d), 32'(bsy[d]), 32'd0);
            check($sformatf("%s_d%0d_idx", tag, d), 32'(oidx[d]), 32'd0);
            check($sformatf("%s_d%0d_data", tag, d), odat[d], 32'd0);
            check($sformatf("%s_d%0d_rsel", tag, d), 32'(rs[d]), 32'd0);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low on cycles 2..6.
    // fwd: write fval to register f during the first READ cycle (f == l).
    task automatic run_sweep(input regbits_t f, input regbits_t l, input int mode,
                             input bit fwd, input word_t fval);
        regbits_t i;
        word_t    v;
        rec_t     e;
        bit       have;
        int       words [2];
        int       skips;
        int       done_exp [2];
        bit       fin [2];
        bit       dprev [2];
        bit       hold [2];
        bit       seen_v [2];
        regbits_t hidx [2];
        word_t    hdat [2];
        string    t;

        q0.delete(); q1.delete();
        words = '{0, 0}; skips = 0;
        fin = '{0, 0}; dprev = '{0, 0}; hold = '{0, 0}; seen_v = '{0, 0};
        hidx = '{5'd0, 5'd0}; hdat = '{32'd0, 32'd0};
        i = f;
        for (int k = 0; k < 32; k++) begin
            v = (fwd && i == f) ? fval : mregs[i];
            q0.push_back({i, v});
            words[0]++;
            if (i == 5'd0) skips++;
            else begin
                q1.push_back({i, v});
                words[1]++;
            end
            if (i == l) break;
            i = i + 5'd1;
        end
        done_exp[0] = 1 + 2 * words[0];
        done_exp[1] = 1 + 2 * words[1] + skips;

        @(negedge CLK);
        first_idx = f; last_idx = l; start = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int cyc = 1; cyc < int'(BOUND); cyc++) begin
            if (fin[0] && fin[1]) break;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(cyc >= 2 && cyc <= 6);
            endcase
            start = 1'b0;
            if (bsy == 2'b11 && (cyc == 1 || $urandom_range(0, 3) == 0)) begin
                start = 1'b1;
                first_idx = 5'($urandom);
                last_idx  = 5'($urandom);
            end
            if (fwd) begin
                WEN = (cyc == 1); wsel = f; wdat = fval;
            end
            for (int d = 0; d < 2; d++) begin
                t = $sformatf("d%0d_%0d..%0d_c%0d", d, f, l, cyc);
                if (dprev[d]) begin
                    check({t, "_done_pulse"}, 32'(dn[d]), 32'd0);
                    check({t, "_idle_busy"}, 32'(bsy[d]), 32'd0);
                    fin[d] = 1'b1;
                    dprev[d] = 1'b0;
                end else if (!fin[d]) begin
                    check({t, "_busy"}, 32'(bsy[d]), 32'd1);
                    if (hold[d]) begin
                        check({t, "_hold_valid"}, 32'(vld[d]), 32'd1);
                        check({t, "_hold_idx"}, 32'(oidx[d]), 32'(hidx[d]));
                        check({t, "_hold_data"}, odat[d], hdat[d]);
                    end
                    if (vld[d]) begin
                        check({t, "_rsel_hold"}, 32'(rs[d]), 32'd0);
                        if (!seen_v[d]) begin
                            seen_v[d] = 1'b1;
                            check({t, "_latency"}, 32'(cyc), (d == 1 && f == 5'd0) ? 32'd3 : 32'd2);
                        end
                        if (out_ready) begin
                            have = 1'b0;
                            e = '0;
                            if (d == 0) begin
                                have = (q0.size() > 0);
                                if (have) e = q0.pop_front();
                            end else begin
                                have = (q1.size() > 0);
                                if (have) e = q1.pop_front();
                            end
                            if (!have) check({t, "_extra_word"}, 32'd1, 32'd0);
                            else begin
                                check({t, "_idx"}, 32'(oidx[d]), 32'(e.idx));
                                check({t, "_data"}, odat[d], e.data);
                            end
                        end
                    end
                    hold[d] = vld[d] && !out_ready;
                    hidx[d] = oidx[d];
                    hdat[d] = odat[d];
                    if (dn[d]) begin
                        check({t, "_words_left"}, (d == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'd0);
                        if (mode == 0) check({t, "_done_cycle"}, 32'(cyc), 32'(done_exp[d]));
                        dprev[d] = 1'b1;
                    end
                end
            end
            @(negedge CLK);
        end
        start = 1'b0;
        WEN = 1'b0;
        if (!(fin[0] && fin[1])) check($sformatf("timeout_%0d..%0d", f, l), 32'd0, 32'd1);
        if (fwd && f != 5'd0) mregs[f] = fval;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mregs[k] = '0;
        RST = 1'b1; nRST = 1'b0; WEN = 1'b0; wsel = '0; wdat = '0;
        start = 1'b0; first_idx = '0; last_idx = '0; out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0; nRST = 1'b1;

        rf_write(5'd1, 32'h11);
        rf_write(5'd2, 32'h22);
        rf_write(5'd3, 32'h33);
        run_sweep(5'd1, 5'd3, 0, 1'b0, '0);
        run_sweep(5'd30, 5'd1, 0, 1'b0, '0);
        run_sweep(5'd31, 5'd1, 0, 1'b0, '0);
        run_sweep(5'd2, 5'd4, 2, 1'b0, '0);
        run_sweep(5'd0, 5'd0, 0, 1'b0, '0);
        run_sweep(5'd7, 5'd7, 0, 1'b0, '0);
        run_sweep(5'd5, 5'd5, 0, 1'b1, 32'hDEAD);

        // Asynchronous reset while both sequencers hold a word of a 0..31 sweep.
        @(negedge CLK);
        first_idx = 5'd0; last_idx = 5'd31; start = 1'b1; out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_reset_valid0", 32'(vld[0]), 32'd1);
        check("pre_reset_valid1", 32'(vld[1]), 32'd1);
        #2 RST = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge CLK);
        check_all_zero("reset_held");
        RST = 1'b0; out_ready = 1'b1;
        run_sweep(5'd0, 5'd31, 0, 1'b0, '0);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) rf_write(5'($urandom), $urandom);
            run_sweep(5'($urandom), 5'($urandom), int'($urandom_range(0, 1)), 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 0; when 1, register index 0 is passed over without emitting a word.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a sweep; sampled only in IDLE.
REQ-006 SHALL have port first_idx  input  5  first register of the sweep; latched on accepted start.
REQ-007 SHALL have port last_idx  input  5  last register of the sweep; latched on accepted start.
REQ-008 SHALL have port rsel  output  5  register-file read select.
REQ-009 SHALL have port rdat  input  32  register-file read data; combinational from rsel.
REQ-010 SHALL have port out_valid  output  1  out_idx/out_data hold a valid word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-012 SHALL have port out_idx  output  5  register index of the emitted word.
REQ-013 SHALL have port out_data  output  32  captured register value.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-016 SHALL implement FSM states IDLE, READ, HOLD, DONE.
REQ-017 In IDLE with start=1, SHALL latch cur=first_idx and end=last_idx, then go to READ.
REQ-018 In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-019 In READ, SHALL drive rsel=cur.
REQ-020 At the end of a READ cycle, SHALL register out_data=rdat and out_idx=cur, set out_valid=1, and go to HOLD.
REQ-021 In READ with SKIP_ZERO=1 and cur=0, SHALL NOT capture a word; it SHALL advance as in REQ-023 directly from READ.
REQ-022 In HOLD, SHALL keep out_valid, out_idx and out_data stable until out_ready=1.
REQ-023 On handshake (out_valid and out_ready both 1), SHALL clear out_valid; if cur==end it SHALL go to DONE, otherwise it SHALL set cur=cur+1 mod 32 and go to READ.
REQ-024 Throughput SHALL be one word per 2 cycles with out_ready held high.
REQ-025 Latency from accepted start to first out_valid SHALL be 2 cycles.
REQ-026 When last_idx < first_idx, the sweep SHALL wrap from 31 to 0 (e.g. 30,31,0,1).
REQ-027 When first_idx == last_idx, the sweep SHALL be exactly one register.
REQ-028 A SKIP_ZERO=1 sweep of 0..0 SHALL emit nothing and reach DONE 2 cycles after start.
REQ-029 DONE SHALL assert done for 1 cycle, then return to IDLE; start in DONE SHALL be ignored.
REQ-030 start asserted in READ, HOLD or DONE SHALL be ignored and SHALL NOT alter first_idx/last_idx latches.
REQ-031 out_data SHALL be the value presented on rdat during the READ cycle, including any same-cycle forwarded write.
REQ-032 In every state other than READ, rsel SHALL be 0.

Reset
REQ-033 On RST=1, the FSM SHALL go to IDLE immediately, regardless of clock, including mid-sweep.
REQ-034 On RST=1, out_valid, done, busy, out_idx, out_data, rsel and cur/end SHALL all be 0.
REQ-035 On RST=1, an in-flight word SHALL be dropped without handshake.

Structure
REQ-036 SHALL use word_t and regbits_t from cpu_types_pkg.
REQ-037 SHALL place the FSM state enum dump_state_t in cpu_types_pkg.
REQ-038 SHALL be a single module with no sub-modules.
REQ-039 The bench SHALL pair the block with register_file, connecting rsel to rsel1 and rdat to rdat1.

Verification
REQ-040 Preload regs 1..3 with 0x11,0x22,0x33; start first=1, last=3, out_ready=1 -> words (1,0x11),(2,0x22),(3,0x33) on cycles 2,4,6; done on cycle 7.
REQ-041 Sweep first=30, last=1 -> out_idx sequence 30,31,0,1; word for idx 0 has data 0.
REQ-042 Hold out_ready=0 for 5 cycles during HOLD -> out_valid, out_idx and out_data stay constant; sweep resumes after out_ready=1.
REQ-043 SKIP_ZERO=1, sweep 31..1 -> words only for idx 31 and 1, then done.
REQ-044 Assert RST asynchronously during HOLD of a 0..31 sweep -> all outputs 0 immediately; a new start after reset release sweeps correctly.
REQ-045 Write reg 5 = 0xDEAD in the same cycle the block reads reg 5 -> out_data = 0xDEAD; start pulsed while busy -> ignored.
